// File: rtl/fixed_point_dot.sv
// Sequential fixed-point dot product: latches two vectors, streams element pairs
// through one multiplier, and returns the wrapped sum with a sticky overflow flag.

module fixed_point_mul #(
  parameter int W = 32,
  parameter int F = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p,
  output logic         ovf
);
  logic signed [2*W-1:0] a_ext;
  logic signed [2*W-1:0] b_ext;
  logic signed [2*W-1:0] full;
  logic signed [2*W-1:0] shifted;
  logic        [W:0]     hi;

  always_comb begin
    a_ext   = {{W{a[W-1]}}, a};
    b_ext   = {{W{b[W-1]}}, b};
    full    = a_ext * b_ext;
    shifted = full >>> F;
    p       = shifted[W-1:0];
    // Result fits only if everything above the kept sign bit is pure sign extension.
    hi      = shifted[2*W-1:W-1];
    ovf     = ~((&hi) | ~(|hi));
  end
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready=1
// ACC   | one multiply-accumulate per cycle, idx walks 0..N_TERMS-1
// DONE  | result presented until out_ready; may accept next operands same edge
module fixed_point_dot #(
  parameter int N_TERMS          = 4,
  parameter int FIXED_W          = 32,
  parameter int FIXED_FRACTION_W = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_TERMS-1:0][FIXED_W-1:0] in_a,
  input  logic [N_TERMS-1:0][FIXED_W-1:0] in_b,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [FIXED_W-1:0]              out_result,
  output logic                            out_overflow
);
  localparam int IDX_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TERMS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                      state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [N_TERMS-1:0][FIXED_W-1:0] a_q, a_d;
  logic [N_TERMS-1:0][FIXED_W-1:0] b_q, b_d;
  logic [FIXED_W-1:0]              acc_q, acc_d;
  logic                            ovf_q, ovf_d;

  logic [FIXED_W-1:0] mul_a;
  logic [FIXED_W-1:0] mul_b;
  logic [FIXED_W-1:0] prod;
  logic               mul_ovf;
  logic [FIXED_W-1:0] sum;
  logic               add_ovf;
  logic               accept;

  assign mul_a = a_q[idx_q];
  assign mul_b = b_q[idx_q];

  fixed_point_mul #(
    .W (FIXED_W),
    .F (FIXED_FRACTION_W)
  ) u_mul (
    .a   (mul_a),
    .b   (mul_b),
    .p   (prod),
    .ovf (mul_ovf)
  );

  always_comb begin
    sum     = acc_q + prod;
    add_ovf = (acc_q[FIXED_W-1] == prod[FIXED_W-1]) &&
              (sum[FIXED_W-1] != acc_q[FIXED_W-1]);

    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept   = in_valid && in_ready;

    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;

    case (state_q)
      ACC: begin
        acc_d = sum;
        ovf_d = ovf_q | mul_ovf | add_ovf;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: ;
    endcase

    // Accept overrides: entering from IDLE or straight out of DONE.
    if (accept) begin
      a_d     = in_a;
      b_d     = in_b;
      acc_d   = '0;
      ovf_d   = 1'b0;
      idx_d   = '0;
      state_d = ACC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid    = (state_q == DONE);
  assign out_result   = acc_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_fixed_point_dot.sv
// Bench for fixed_point_dot: directed cases with literal results plus randomized
// traffic checked every cycle against an integer-arithmetic dot-product model.

module tb_fixed_point_dot;
  localparam int N = 4;
  typedef logic [N-1:0][31:0] vec_t;
  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          acc_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  vec_t        in_a = '0;
  vec_t        in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_overflow;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   rand_mode = 1'b0;
  exp_t q[$];

  fixed_point_dot #(
    .N_TERMS          (N),
    .FIXED_W          (32),
    .FIXED_FRACTION_W (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact products, range-checked against the signed 32-bit window.
  function automatic void model(input vec_t a, input vec_t b,
                                output logic [31:0] res, output logic ovf);
    longint acc = 0;
    ovf = 1'b0;
    for (int i = 0; i < N; i++) begin
      longint p = (longint'($signed(a[i])) * longint'($signed(b[i]))) >>> 16;
      longint s;
      int     p32;
      if (p > 64'sd2147483647 || p < -64'sd2147483648) ovf = 1'b1;
      p32 = int'(p);
      s   = acc + longint'(p32);
      if (s > 64'sd2147483647 || s < -64'sd2147483648) ovf = 1'b1;
      acc = longint'(int'(s));
    end
    res = acc[31:0];
  endfunction

  // Cycle-by-cycle compare against the queue of expected results.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      logic exp_valid;
      exp_valid = (q.size() > 0) && (cyc >= q[0].acc_cyc + N);
      chk("out_valid", 64'(out_valid), 64'(exp_valid));
      chk("in_ready", 64'(in_ready), 64'((q.size() == 0) || (exp_valid && out_ready)));
      if (exp_valid && out_valid) begin
        chk("out_result", 64'(out_result), 64'(q[0].res));
        chk("out_overflow", 64'(out_overflow), 64'(q[0].ovf));
      end
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        exp_t e;
        model(in_a, in_b, e.res, e.ovf);
        e.acc_cyc = cyc + 1;
        q.push_back(e);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
  end

  function automatic logic [31:0] rand_elem();
    int v;
    if ($urandom_range(0, 3) == 0) return $urandom;
    v = int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19);
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = rand_elem();
    return v;
  endfunction

  task automatic send(input vec_t a, input vec_t b);
    bit ok = 1'b0;
    @(posedge clk); #1;
    in_a = a; in_b = b; in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = rand_vec(); in_b = rand_vec();
  endtask

  task automatic do_op(input string name, input vec_t a, input vec_t b,
                       input logic [31:0] exp_res, input logic exp_ovf);
    logic [31:0] mr;
    logic        mo;
    int          lat = -1;
    model(a, b, mr, mo);
    chk({name, "_model_res"}, 64'(mr), 64'(exp_res));
    chk({name, "_model_ovf"}, 64'(mo), 64'(exp_ovf));
    send(a, b);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin lat = i; break; end
    end
    chk({name, "_latency"}, 64'(lat), 64'(N));
    chk({name, "_res"}, 64'(out_result), 64'(exp_res));
    chk({name, "_ovf"}, 64'(out_overflow), 64'(exp_ovf));
  endtask

  initial begin
    vec_t a, b;
    logic [31:0] held;
    logic        done;

    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_overflow", 64'(out_overflow), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;

    a = {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
    b = {4{32'h0000_8000}};
    do_op("basic", a, b, 32'h0005_0000, 1'b0);

    a = {32'h0, 32'h0, 32'h0002_0000, 32'hFFFE_8000};
    b = {32'h0007_0000, 32'h0007_0000, 32'hFFFF_C000, 32'h0002_0000};
    do_op("signs", a, b, 32'hFFFC_8000, 1'b0);

    a = {32'h0, 32'h0, 32'h4E20_0000, 32'h4E20_0000};
    b = {32'h0, 32'h0, 32'h0001_0000, 32'h0001_0000};
    do_op("sum_ovf", a, b, 32'h9C40_0000, 1'b1);

    a = {32'h0, 32'h0, 32'h0, 32'h012C_0000};
    do_op("prod_ovf", a, a, 32'h5F90_0000, 1'b1);

    a = {32'h0, 32'h0, 32'h0, 32'h0001_0000};
    do_op("sticky_clr", a, a, 32'h0001_0000, 1'b0);

    // Backpressure: hold the result, then accept new operands on the release edge.
    @(posedge clk); #1 out_ready = 1'b0;
    a = {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
    b = {4{32'h0001_0000}};
    send(a, b);
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin done = 1'b1; break; end
    end
    chk("bp_valid_seen", 64'(done), 64'd1);
    held = out_result;
    chk("bp_result", 64'(held), 64'h000A_0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_result", 64'(out_result), 64'(held));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_a = {32'h0, 32'h0, 32'h0, 32'h0003_0000};
    in_b = {32'h0, 32'h0, 32'h0, 32'h0002_0000};
    in_valid = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = rand_vec(); in_b = rand_vec();
    for (int k = 0; k <= N; k++) begin
      @(negedge clk);
      chk("b2b_valid_timing", 64'(out_valid), 64'(k == N));
    end
    chk("b2b_result", 64'(out_result), 64'h0006_0000);

    // Reset two cycles into an operation discards it.
    a = {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
    send(a, a);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_result", 64'(out_result), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_no_stale", 64'(out_valid), 64'd0);
    end

    rand_mode = 1'b1;
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send(rand_vec(), rand_vec());
    end
    rand_mode = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q.size() == 0) begin done = 1'b1; break; end
    end
    chk("drain", 64'(done), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_point_dot.md
# fixed_point_dot

Sequential fixed-point dot-product engine for the vertex transform path. It accepts a pair of N_TERMS-element vectors through a valid/ready handshake and streams one element pair per cycle through a single `fixed_point_mul` instance. It accumulates the products into a FIXED_W-bit fixed-point sum and returns that sum with a sticky overflow flag. Matrix-vector stages downstream issue one dot product per output component.

## Interface
- `N_TERMS`, default 4: number of element pairs per dot product (vec4 homogeneous coordinates); must be ≥1.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operand vectors present.
- `in_ready`  out  1  block can accept operands this cycle.
- `in_a`  in  N_TERMS x `FIXED_W` (`fixed_point_t` array)  vector A, element 0 first.
- `in_b`  in  N_TERMS x `FIXED_W` (`fixed_point_t` array)  vector B.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer takes the result.
- `out_result`  out  `FIXED_W` (`fixed_point_t`)  sum of a[i]*b[i].
- `out_overflow`  out  1  any product or partial sum overflowed during this operation.

## Operation
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch both vectors, clear the accumulator and the sticky flag, set idx=0, go to ACC.
- ACC (N_TERMS cycles):
  - The multiplier sees a[idx] and b[idx].
  - Each edge: acc <= acc + product; sticky |= mul overflow | add overflow; idx++.
  - On the edge where idx==N_TERMS-1, go to DONE.
- DONE:
  - `out_valid`=1; `out_result`/`out_overflow` hold steady.
  - On `out_ready`, go to IDLE.
  - If `in_valid` is also high in that cycle, accept the new operands directly (DONE→ACC).
- `in_ready` = IDLE | (DONE & `out_ready`). Operands are sampled only on an accepting edge; later changes on `in_a`/`in_b` are ignored.
- Arithmetic:
  - Product = full 2*FIXED_W signed product arithmetically shifted right by `FIXED_FRACTION_W`, truncated to FIXED_W bits, with the multiplier's overflow flag.
  - Accumulation is FIXED_W-bit two's-complement and wraps; it does not saturate.
  - Add overflow = operands share a sign and the sum's sign differs.
- Overflow is sticky for the whole operation. It is cleared only on accept.
- `idx` width is $clog2(N_TERMS), minimum 1.

## Timing
- Reset values:
  - state=IDLE, `in_ready`=1, `out_valid`=0.
  - `out_result`=0, `out_overflow`=0, accumulator=0, idx=0.
- Latency: accept on edge E0 → `out_valid` high after edge E0+N_TERMS (4 cycles at default).
- Throughput: one result per N_TERMS+1 cycles with `out_ready` held high. A back-to-back accept in DONE costs no extra cycle.
- Backpressure: `out_valid` stays high and the outputs stay stable until `out_ready`. `in_ready`=0 throughout ACC, and throughout DONE while `out_ready`=0.
- `out_valid` is registered. `in_ready` is combinational only through `out_ready`, with no path from `in_valid`.
- Reset asserted mid-ACC or mid-DONE:
  - Immediately forces the reset values above.
  - The in-flight result is discarded and never presented.
- Zero-valued product with overflow: the flag is still taken as reported by the multiplier.

## Test plan
Default N_TERMS=4; bench configuration `FIXED_W`=32, `FIXED_FRACTION_W`=16.
- Basic: a=(1,2,3,4), b=(0.5,0.5,0.5,0.5) → `out_result`=0x0005_0000 (5.0), overflow=0, `out_valid` exactly 4 edges after accept.
- Signs: a=(-1.5,2,0,0), b=(2,-0.25,7,7) → 0xFFFC_8000 (-3.5), overflow=0.
- Sum overflow: a=(20000,20000,0,0), b=(1,1,0,0) → wraps to 0x9C40_0000, overflow=1.
- Product overflow:
  - a=(300,0,0,0), b=(300,0,0,0) → overflow=1.
  - Immediately after, a=(1,0,0,0), b=(1,0,0,0) → 0x0001_0000, overflow=0 (sticky cleared on accept).
- Backpressure and back-to-back:
  - Hold `out_ready`=0 for 3 cycles in DONE → outputs stable, `in_ready`=0.
  - Raise `out_ready` with `in_valid`=1 → new accept that same edge; next result arrives 4 edges later.
- Reset mid-operation: deassert `rst_n` 2 cycles after accept → `out_valid`=0 and `out_result`=0 immediately. After release, `in_ready`=1 and no stale result appears.
